// File: rtl/float_norm_if.sv
// float_norm_if: handshake and data bundle between adder datapath, normalizer and consumer
interface float_norm_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        overflow;
  logic        underflow;
  modport master (
    output in_valid, sign_in, exp_in, mant_in, out_ready,
    input  in_ready, out_valid, S, overflow, underflow
  );
  modport slave (
    input  in_valid, sign_in, exp_in, mant_in, out_ready,
    output in_ready, out_valid, S, overflow, underflow
  );
endinterface

// File: rtl/float_norm_seq.sv
// float_norm_seq: sequential one-bit-per-cycle normalizer and IEEE-754 single packer
module float_norm_seq (
  input logic        clk,
  input logic        rst,
  float_norm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, PACK, DONE} state_t;
  state_t             r_state;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [24:0]        r_mant;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_ovf;
  logic               r_unf;
  logic [31:0]        r_s;
  logic               w_zero;
  logic               w_ovf;
  logic               w_unf;
  logic [31:0]        w_s;
  // zero beats overflow, overflow beats underflow
  always_comb begin
    w_zero = r_mant == '0;
    w_ovf  = !w_zero && r_exp >= 10'sd255;
    w_unf  = !w_zero && !w_ovf && (r_exp <= 10'sd0 || !r_mant[23]);
    w_s    = w_zero ? 32'h0 :
             w_ovf  ? {r_sign, 8'hFF, 23'h0} :
             w_unf  ? {r_sign, 31'h0} :
                      {r_sign, r_exp[7:0], r_mant[22:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_s         <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_sign     <= bus.sign_in;
          r_exp      <= {2'b00, bus.exp_in};
          r_mant     <= bus.mant_in;
          r_in_ready <= 1'b0;
          r_state    <= SHIFT;
        end
        SHIFT: if (w_zero) r_state <= PACK;
        else if (r_mant[24]) begin
          r_mant  <= r_mant >> 1;
          r_exp   <= r_exp + 10'sd1;
          r_state <= PACK;
        end else if (r_mant[23] || r_exp <= 10'sd1) r_state <= PACK;
        else begin
          r_mant <= r_mant << 1;
          r_exp  <= r_exp - 10'sd1;
        end
        PACK: begin
          r_s         <= w_s;
          r_ovf       <= w_ovf;
          r_unf       <= w_unf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.S         = r_s;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule
